// File: rtl/noc16_reg_bridge_pkg.sv
// Shared definitions for the NOC16 register bridge: command codes,
// register addresses and the bridge FSM state type.
package noc16_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_ECHO  = 8'h03;
  localparam logic [7:0] CMD_ACC   = 8'h04;
  localparam logic [7:0] CMD_CLR   = 8'h05;
  localparam logic [7:0] CMD_ERR   = 8'hFF;
  localparam logic [7:0] RSP_BIT   = 8'h80;

  localparam logic [7:0] ADDR_LEDS   = 8'd0;
  localparam logic [7:0] ADDR_SYND   = 8'd1;
  localparam logic [7:0] ADDR_WAYP   = 8'd2;
  localparam logic [7:0] ADDR_PC     = 8'd3;
  localparam logic [7:0] ADDR_SERIAL = 8'd4;
  localparam logic [7:0] ADDR_SW     = 8'd5;
  localparam logic [7:0] ADDR_ACC_LO = 8'd6;
  localparam logic [7:0] ADDR_ACC_HI = 8'd7;
  localparam logic [7:0] ADDR_LIMIT  = 8'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/noc16_reg_bridge_if.sv
// NOC16 service channel: Tx request flits into the bridge, Rx response flits out.
interface noc16_reg_bridge_if;
  logic [63:0] tx_data_lo;
  logic [7:0]  tx_data_cmd;
  logic        tx_data_valid;
  logic        tx_data_rdy;
  logic [63:0] rx_data_lo;
  logic [7:0]  rx_data_cmd;
  logic        rx_data_valid;
  logic        rx_data_rdy;

  modport master (
    output tx_data_lo, tx_data_cmd, tx_data_valid, rx_data_rdy,
    input  tx_data_rdy, rx_data_lo, rx_data_cmd, rx_data_valid
  );

  modport slave (
    input  tx_data_lo, tx_data_cmd, tx_data_valid, rx_data_rdy,
    output tx_data_rdy, rx_data_lo, rx_data_cmd, rx_data_valid
  );
endinterface

// File: rtl/noc16_reg_bridge_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, async active-high reset.
module sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/noc16_reg_bridge.sv
// NOC16 register bridge: one request at a time; IDLE captures the flit, EXEC applies
// side effects and registers the response, RESP holds it until the Rx handshake.
module noc16_reg_bridge
  import noc16_pkg::*;
#(
  parameter logic [31:0] SERIAL_NUMBER = 32'd1236
) (
  input  logic              clk,
  input  logic              reset,
  noc16_reg_bridge_if.slave bus,
  input  logic [7:0]        gpio_switches,
  output logic [7:0]        gpio_leds,
  output logic [7:0]        abend_syndrome,
  output logic [7:0]        manual_waypoint,
  output logic [4:0]        pc_export,
  output logic [31:0]       result_hi,
  output logic [31:0]       result_lo
);
  state_e      state_q, state_d;
  logic        rdy_en_q;
  logic [7:0]  cmd_q, cmd_d;
  logic [63:0] pay_q, pay_d;
  logic [7:0]  leds_q, leds_d;
  logic [7:0]  synd_q, synd_d;
  logic [7:0]  wayp_q, wayp_d;
  logic [4:0]  pc_q, pc_d;
  logic [63:0] acc_q, acc_d;
  logic [7:0]  rsp_cmd_q, rsp_cmd_d;
  logic [63:0] rsp_lo_q, rsp_lo_d;
  logic [7:0]  sw_sync;
  logic [7:0]  addr;
  logic [31:0] rd_word;
  logic        err;

  sync2 #(.WIDTH(8)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (gpio_switches),
    .q_o   (sw_sync)
  );

  assign addr = pay_q[63:56];

  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_LEDS:   rd_word = {24'b0, leds_q};
      ADDR_SYND:   rd_word = {24'b0, synd_q};
      ADDR_WAYP:   rd_word = {24'b0, wayp_q};
      ADDR_PC:     rd_word = {27'b0, pc_q};
      ADDR_SERIAL: rd_word = SERIAL_NUMBER;
      ADDR_SW:     rd_word = {24'b0, sw_sync};
      ADDR_ACC_LO: rd_word = acc_q[31:0];
      ADDR_ACC_HI: rd_word = acc_q[63:32];
      default:     rd_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    pay_d     = pay_q;
    leds_d    = leds_q;
    synd_d    = synd_q;
    wayp_d    = wayp_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    rsp_cmd_d = rsp_cmd_q;
    rsp_lo_d  = rsp_lo_q;
    err       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rdy_en_q && bus.tx_data_valid) begin
          cmd_d   = bus.tx_data_cmd;
          pay_d   = bus.tx_data_lo;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d   = ST_RESP;
        rsp_cmd_d = cmd_q | RSP_BIT;
        rsp_lo_d  = '0;
        case (cmd_q)
          CMD_WRITE: begin
            case (addr)
              ADDR_LEDS: begin leds_d = pay_q[7:0]; rsp_lo_d = {56'b0, pay_q[7:0]}; end
              ADDR_SYND: begin synd_d = pay_q[7:0]; rsp_lo_d = {56'b0, pay_q[7:0]}; end
              ADDR_WAYP: begin wayp_d = pay_q[7:0]; rsp_lo_d = {56'b0, pay_q[7:0]}; end
              ADDR_PC:   begin pc_d   = pay_q[4:0]; rsp_lo_d = {59'b0, pay_q[4:0]}; end
              default:   err = 1'b1;
            endcase
          end
          CMD_READ: begin
            if (addr < ADDR_LIMIT) rsp_lo_d = {32'b0, rd_word};
            else                   err      = 1'b1;
          end
          CMD_ECHO: rsp_lo_d = pay_q;
          CMD_ACC: begin
            acc_d    = acc_q + pay_q;
            rsp_lo_d = acc_q + pay_q;
          end
          CMD_CLR:  acc_d = '0;
          default:  err = 1'b1;
        endcase
        // Error flits override the success response; register updates above are not taken on any error path.
        if (err) begin
          rsp_cmd_d = CMD_ERR;
          rsp_lo_d  = {56'b0, cmd_q};
        end
      end
      ST_RESP: begin
        if (bus.rx_data_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rdy_en_q  <= 1'b0;
      cmd_q     <= '0;
      pay_q     <= '0;
      leds_q    <= '0;
      synd_q    <= '0;
      wayp_q    <= '0;
      pc_q      <= '0;
      acc_q     <= '0;
      rsp_cmd_q <= '0;
      rsp_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      cmd_q     <= cmd_d;
      pay_q     <= pay_d;
      leds_q    <= leds_d;
      synd_q    <= synd_d;
      wayp_q    <= wayp_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      rsp_cmd_q <= rsp_cmd_d;
      rsp_lo_q  <= rsp_lo_d;
    end
  end

  // Ready comes only from registered state so there is no valid-to-ready path.
  assign bus.tx_data_rdy   = (state_q == ST_IDLE) && rdy_en_q;
  assign bus.rx_data_valid = (state_q == ST_RESP);
  assign bus.rx_data_cmd   = rsp_cmd_q;
  assign bus.rx_data_lo    = rsp_lo_q;

  assign gpio_leds       = leds_q;
  assign abend_syndrome  = synd_q;
  assign manual_waypoint = wayp_q;
  assign pc_export       = pc_q;
  assign result_hi       = acc_q[63:32];
  assign result_lo       = acc_q[31:0];
endmodule

// File: tb/tb_noc16_reg_bridge.sv
// Randomized bench for noc16_reg_bridge with a transaction-level reference model
// compared against every DUT output on every cycle, plus directed literal checks.
module tb_noc16_reg_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sw  = 8'h00;
  logic [7:0]  gpio_leds, abend_syndrome, manual_waypoint;
  logic [4:0]  pc_export;
  logic [31:0] result_hi, result_lo;

  noc16_reg_bridge_if bus ();

  noc16_reg_bridge #(.SERIAL_NUMBER(32'd1236)) dut (
    .clk             (clk),
    .reset           (rst),
    .bus             (bus),
    .gpio_switches   (sw),
    .gpio_leds       (gpio_leds),
    .abend_syndrome  (abend_syndrome),
    .manual_waypoint (manual_waypoint),
    .pc_export       (pc_export),
    .result_hi       (result_hi),
    .result_lo       (result_lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_reg [4];
  logic [63:0] m_acc = '0;
  logic [7:0]  m_s1 = '0, m_s2 = '0;
  logic        m_tx_rdy = 1'b0, m_rx_valid = 1'b0, m_exec_due = 1'b0;
  logic [7:0]  m_cmd = '0, m_rsp_cmd = '0;
  logic [63:0] m_pay = '0, m_rsp_lo = '0;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a < 8'd4)       return {24'b0, m_reg[a[1:0]]};
    else if (a == 8'd4) return 32'd1236;
    else if (a == 8'd5) return {24'b0, m_s2};
    else if (a == 8'd6) return m_acc[31:0];
    else                return m_acc[63:32];
  endfunction

  task automatic model_exec();
    logic [7:0] a;
    logic       bad;
    a   = m_pay[63:56];
    bad = 1'b0;
    m_rsp_cmd = m_cmd | 8'h80;
    m_rsp_lo  = 64'd0;
    case (m_cmd)
      8'h01: if (a < 8'd4) begin
               m_reg[a[1:0]] = m_pay[7:0] & ((a == 8'd3) ? 8'h1F : 8'hFF);
               m_rsp_lo = {56'd0, m_reg[a[1:0]]};
             end else bad = 1'b1;
      8'h02: if (a < 8'd8) m_rsp_lo = {32'd0, model_read(a)};
             else bad = 1'b1;
      8'h03: m_rsp_lo = m_pay;
      8'h04: begin m_acc = m_acc + m_pay; m_rsp_lo = m_acc; end
      8'h05: m_acc = 64'd0;
      default: bad = 1'b1;
    endcase
    if (bad) begin
      m_rsp_cmd = 8'hFF;
      m_rsp_lo  = {56'd0, m_cmd};
    end
  endtask

  // Transaction timeline: accept edge, then one edge later results appear, held until Rx handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_acc = '0; m_s1 = '0; m_s2 = '0;
      m_tx_rdy = 1'b0; m_rx_valid = 1'b0; m_exec_due = 1'b0;
    end else begin
      if (m_exec_due) begin
        model_exec();
        m_exec_due = 1'b0;
        m_rx_valid = 1'b1;
      end else if (m_rx_valid) begin
        if (bus.rx_data_rdy) begin
          m_rx_valid = 1'b0;
          m_tx_rdy   = 1'b1;
        end
      end else if (m_tx_rdy) begin
        if (bus.tx_data_valid) begin
          m_cmd = bus.tx_data_cmd;
          m_pay = bus.tx_data_lo;
          m_tx_rdy   = 1'b0;
          m_exec_due = 1'b1;
        end
      end else begin
        m_tx_rdy = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tx_rdy",   bus.tx_data_rdy,   m_tx_rdy);
      chk("m_rx_valid", bus.rx_data_valid, m_rx_valid);
      if (m_rx_valid) begin
        chk("m_rx_cmd", bus.rx_data_cmd, m_rsp_cmd);
        chk("m_rx_lo",  bus.rx_data_lo,  m_rsp_lo);
      end
      chk("m_leds",  gpio_leds,       m_reg[0]);
      chk("m_synd",  abend_syndrome,  m_reg[1]);
      chk("m_wayp",  manual_waypoint, m_reg[2]);
      chk("m_pc",    pc_export,       m_reg[3][4:0]);
      chk("m_acc",   {result_hi, result_lo}, m_acc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [7:0] c, input logic [63:0] d, input int hold,
                        output logic [7:0] rc, output logic [63:0] rl);
    int t;
    int lat;
    rc = '0;
    rl = '0;
    @(negedge clk);
    bus.tx_data_cmd = c; bus.tx_data_lo = d; bus.tx_data_valid = 1'b1; bus.rx_data_rdy = 1'b0;
    t = 0;
    while (!bus.tx_data_rdy && t < 100) begin @(negedge clk); t++; end
    if (!bus.tx_data_rdy) begin
      chk("accept_timeout", 64'd1, 64'd0);
      bus.tx_data_valid = 1'b0;
      return;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.tx_data_valid = 1'b0;
    end while (!bus.rx_data_valid && lat < 100);
    chk("latency", lat, 2);
    if (!bus.rx_data_valid) return;
    repeat (hold) @(negedge clk);
    rc = bus.rx_data_cmd;
    rl = bus.rx_data_lo;
    bus.rx_data_rdy = 1'b1;
    @(negedge clk);
    bus.rx_data_rdy = 1'b0;
  endtask

  function automatic logic [63:0] pay(input logic [7:0] a, input logic [31:0] w);
    return {a, 24'd0, w};
  endfunction

  logic [7:0]  rc;
  logic [63:0] rl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.tx_data_cmd = '0; bus.tx_data_lo = '0; bus.tx_data_valid = 1'b0; bus.rx_data_rdy = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_tx_rdy", bus.tx_data_rdy, 0);
    chk("rst_rx_valid", bus.rx_data_valid, 0);
    chk("rst_rx_lo", bus.rx_data_lo, 0);
    chk("rst_rx_cmd", bus.rx_data_cmd, 0);
    chk("rst_regs", {gpio_leds, abend_syndrome, manual_waypoint, 3'b0, pc_export}, 0);
    chk("rst_result", {result_hi, result_lo}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rdy_after_release", bus.tx_data_rdy, 0);
    @(negedge clk);
    chk("rdy_first_edge", bus.tx_data_rdy, 1);

    do_req(8'h01, pay(8'd0, 32'h0000_00A5), 0, rc, rl);
    chk("wr0_cmd", rc, 8'h81); chk("wr0_lo", rl, 64'hA5); chk("wr0_leds", gpio_leds, 8'hA5);
    do_req(8'h01, pay(8'd3, 32'h0000_00FF), 1, rc, rl);
    chk("wr3_lo", rl, 64'h1F); chk("wr3_pc", pc_export, 5'h1F);
    do_req(8'h02, pay(8'd4, 32'd0), 0, rc, rl);
    chk("rd4_cmd", rc, 8'h82); chk("rd4_lo", rl, 64'h4D4);
    do_req(8'h04, 64'hFFFF_FFFF_FFFF_FFFF, 0, rc, rl);
    chk("acc1_lo", rl, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(8'h04, 64'd2, 0, rc, rl);
    chk("acc2_cmd", rc, 8'h84); chk("acc2_lo", rl, 64'd1);
    chk("acc2_res", {result_hi, result_lo}, 64'd1);
    do_req(8'h05, 64'd0, 0, rc, rl);
    chk("clr_cmd", rc, 8'h85); chk("clr_lo", rl, 0); chk("clr_res", {result_hi, result_lo}, 0);
    do_req(8'h3C, pay(8'd0, 32'h11), 0, rc, rl);
    chk("bad_cmd", rc, 8'hFF); chk("bad_lo", rl, 64'h3C);
    do_req(8'h01, pay(8'd6, 32'h55), 0, rc, rl);
    chk("wr6_cmd", rc, 8'hFF); chk("wr6_lo", rl, 64'h01);
    chk("wr6_noeff", {gpio_leds, 3'b0, pc_export}, {8'hA5, 8'h1F});

    // Backpressure: READ leds held 5 cycles while the next flit (ECHO) waits with valid high.
    @(negedge clk);
    bus.tx_data_cmd = 8'h02; bus.tx_data_lo = pay(8'd0, 32'd0); bus.tx_data_valid = 1'b1;
    t = 0;
    while (!bus.tx_data_rdy && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.tx_data_cmd = 8'h03; bus.tx_data_lo = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", bus.rx_data_valid, 1);
      chk("hold_cmd", bus.rx_data_cmd, 8'h82);
      chk("hold_lo", bus.rx_data_lo, 64'hA5);
      chk("hold_txrdy", bus.tx_data_rdy, 0);
      @(negedge clk);
    end
    bus.rx_data_rdy = 1'b1;
    @(negedge clk);
    bus.rx_data_rdy = 1'b0;
    chk("b2b_rdy", bus.tx_data_rdy, 1);
    @(negedge clk);
    bus.tx_data_valid = 1'b0;
    chk("b2b_exec", bus.rx_data_valid, 0);
    @(negedge clk);
    chk("b2b_valid", bus.rx_data_valid, 1);
    chk("b2b_cmd", bus.rx_data_cmd, 8'h83);
    chk("b2b_lo", bus.rx_data_lo, 64'h1234_5678_9ABC_DEF0);
    bus.rx_data_rdy = 1'b1;
    @(negedge clk);
    bus.rx_data_rdy = 1'b0;

    // Reset while a response is pending.
    @(negedge clk);
    bus.tx_data_cmd = 8'h01; bus.tx_data_lo = pay(8'd1, 32'h77); bus.tx_data_valid = 1'b1;
    t = 0;
    while (!bus.tx_data_rdy && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.tx_data_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", bus.rx_data_valid, 1);
    chk("pre_rst_synd", abend_syndrome, 8'h77);
    #2 rst = 1'b1;
    #1 chk("rst_drop_valid", bus.rx_data_valid, 0);
    chk("rst_clear_leds", gpio_leds, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    do_req(8'h02, pay(8'd5, 32'd0), 0, rc, rl);
    chk("sw_cmd", rc, 8'h82); chk("sw_lo", rl, 64'h3C);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int n = 0; n < 200; n++) begin
      logic [7:0]  c, a;
      logic [63:0] d;
      int          r;
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      r = $urandom_range(0, 9);
      c = (r < 3) ? 8'h01 : (r < 5) ? 8'h02 : (r == 5) ? 8'h03 :
          (r < 8) ? 8'h04 : (r == 8) ? 8'h05 : 8'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      d = {$urandom, $urandom};
      if (c != 8'h04 && c != 8'h03) d[63:56] = a;
      do_req(c, d, $urandom_range(0, 3), rc, rl);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/noc16_reg_bridge.md
# noc16_reg_bridge

Register-access bridge on the NOC16 service channel of the peripheral device. Consumes request flits (8-bit command + 64-bit payload) arriving on the Tx channel and executes register writes, reads, echoes and 64-bit accumulations against a small control register file. Returns exactly one response flit per request on the Rx channel. Owns the GPIO LED, abend syndrome, manual waypoint and PC-export registers, and drives the 64-bit result outputs.

## Interface
Parameters:
- SERIAL_NUMBER, 32'd1236, read-only value returned at address 4.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tx_data_lo  in  64  request payload.
- tx_data_cmd  in  8  request command.
- tx_data_valid  in  1  request flit valid.
- tx_data_rdy  out  1  bridge can accept a request.
- rx_data_lo  out  64  response payload.
- rx_data_cmd  out  8  response command.
- rx_data_valid  out  1  response flit valid.
- rx_data_rdy  in  1  downstream accepts the response.
- gpio_switches  in  8  asynchronous switch inputs.
- gpio_leds  out  8  LED register (addr 0).
- abend_syndrome  out  8  syndrome register (addr 1).
- manual_waypoint  out  8  waypoint register (addr 2).
- pc_export  out  5  PC export register (addr 3).
- result_hi  out  32  accumulator bits [63:32].
- result_lo  out  32  accumulator bits [31:0].

## Operation
- Request fields: addr = tx_data_lo[63:56]; wdata = tx_data_lo[31:0]. The full 64 bits are used for ECHO and ACC.
- Commands:
  - 0x01 WRITE: write wdata, truncated to register width, to addr.
  - 0x02 READ: return the register zero-extended into rx_data_lo[31:0], with rx_data_lo[63:32] = 0.
  - 0x03 ECHO: return the payload unchanged.
  - 0x04 ACC: acc <= acc + payload, mod 2^64; return the new acc.
  - 0x05 CLR: acc <= 0; return 0.
- Register map:
  - 0 leds (8 bits, RW)
  - 1 syndrome (8 bits, RW)
  - 2 waypoint (8 bits, RW)
  - 3 pc_export (5 bits, RW)
  - 4 SERIAL_NUMBER (RO)
  - 5 synchronized switches (RO)
  - 6 acc[31:0] (RO)
  - 7 acc[63:32] (RO)
- Response cmd = request cmd | 0x80 on success.
- Error response: cmd = 0xFF, rx_data_lo = {56'b0, request cmd}. An error has no side effect. Errors are raised for:
  - any other command;
  - WRITE to address 4–255;
  - READ from address 8–255.
- The WRITE response payload echoes the written value after truncation.
- gpio_switches pass through a 2-flop synchronizer before readback.
- FSM states:
  - IDLE: tx_data_rdy = 1. On tx_data_valid, capture cmd and payload, then go to EXEC.
  - EXEC: perform the side effect, form the response into the output register, go to RESP.
  - RESP: rx_data_valid = 1. On rx_data_rdy, go to IDLE.
- One request outstanding at a time; no pipelining.

## Timing
- Reset values: all outputs 0, including rx_data_valid and result_*; FSM in IDLE. tx_data_rdy goes to 1 on the first clock edge after reset deasserts.
- Accept in cycle N means rx_data_valid is high from cycle N+2.
- Register and accumulator outputs update at the edge ending EXEC, visible in cycle N+2.
- Rx outputs are registered and remain stable while valid and not ready.
- rx_data_rdy high on the first RESP cycle: IDLE in N+3, next accept in N+3. Peak rate is one request per 3 cycles.
- tx_data_rdy is combinationally decoded from state only; there is no path from valid to rdy.
- tx_data_valid while not in IDLE is ignored; the upstream holds the flit.
- Reset mid-transaction:
  - the pending response is dropped;
  - no partial write occurs unless EXEC's edge has already completed.
- ACC overflow wraps silently with no error.

## Structure
- Shared package `noc16_pkg`:
  - command codes (CMD_WRITE, CMD_READ, CMD_ECHO, CMD_ACC, CMD_CLR, CMD_ERR = 8'hFF, RSP_BIT = 8'h80);
  - register address constants;
  - FSM state encoding.
- Sub-module `sync2`: 2-flop synchronizer for gpio_switches, parameterized width, async reset.
- The register file, accumulator and FSM stay in a single module.

## Test plan
- After reset: all outputs 0 and tx_data_rdy = 1. Issue WRITE addr 0, data 0x000000A5 → response cmd 0x81, lo = 0xA5, gpio_leds = 0xA5 in cycle N+2.
- WRITE addr 3, data 0xFF → pc_export = 5'h1F. Then READ addr 4 → cmd 0x82, lo = 0x4D4 (1236).
- ACC with 0xFFFFFFFF_FFFFFFFF, then ACC with 2 → second response lo = 1, result_hi = 0, result_lo = 1. CLR → all 0.
- cmd 0x3C, and WRITE addr 6 → each returns cmd 0xFF with lo = 0x3C or 0x01 respectively; no register changes.
- Hold rx_data_rdy low for 5 cycles while tx_data_valid stays high:
  - response is stable;
  - tx_data_rdy is 0;
  - second request is accepted the cycle after the rx handshake.
- Assert reset during RESP → rx_data_valid drops immediately. Drive gpio_switches = 0x3C, wait 3 cycles, READ addr 5 → lo = 0x3C.
